// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between ALU writeback
//            and buffered load returns. ALU has default priority; a starvation
//            guard forces a load write after STARVE_LIMIT blocked cycles. A
//            per-register busy scoreboard lets decode stall on RAW hazards
//            against in-flight loads.
// Options  : WB_ARB_PERF_EN - adds conflict_cnt / forced_cnt perf counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    output logic            dec_stall,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd3
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]     conflict_cnt,
    output logic [31:0]     forced_cnt
`endif
);

    localparam int c_PTR_W = $clog2(LQ_DEPTH);
    localparam int c_CNT_W = $clog2(STARVE_LIMIT + 1) + 1;
    localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(LQ_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        PRI_ALU  = 1'b0,
        PRI_LOAD = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_starve;
    logic [4:0]           r_fifo_rd   [LQ_DEPTH];
    logic [XLEN-1:0]      r_fifo_data [LQ_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [31:0]          r_busy;

    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_grant_alu;
    logic                 w_grant_ld;
    logic                 w_conflict;
    logic                 w_enter_load;
    logic [c_CNT_W-1:0]   w_starve_inc;
    logic [4:0]           w_head_rd;
    logic [XLEN-1:0]      w_head_data;
    logic [31:0]          w_busy_nxt;

    assign w_empty     = (r_count == '0);
    assign ld_ready    = (r_count != c_FULL);
    assign w_push      = ld_valid & ld_ready;
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // ALU wins in PRI_ALU; in PRI_LOAD only the FIFO head may write
    assign alu_ready    = (r_state == PRI_ALU);
    assign w_grant_alu  = alu_ready & alu_valid;
    assign w_grant_ld   = ~w_grant_alu & ~w_empty;
    assign w_pop        = w_grant_ld;
    assign w_conflict   = alu_valid & ~w_empty;
    assign w_starve_inc = r_starve + c_CNT_W'(1);
    assign w_enter_load = (r_state == PRI_ALU) & w_conflict & (w_starve_inc >= c_LIMIT);

    assign dec_stall = r_busy[dec_rs1] | r_busy[dec_rs2] | r_busy[dec_rd];

    // Load-return storage; contents are only meaningful under r_count, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= ld_rd;
            r_fifo_data[r_wr_ptr] <= ld_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Arbiter state and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= PRI_ALU;
            r_starve <= '0;
        end else begin
            case (r_state)
                PRI_ALU: begin
                    if (w_enter_load) begin
                        r_state  <= PRI_LOAD;
                        r_starve <= '0;
                    end else if (w_conflict) begin
                        r_starve <= w_starve_inc;
                    end else begin
                        r_starve <= '0;
                    end
                end
                default: begin
                    r_state  <= PRI_ALU;
                    r_starve <= '0;
                end
            endcase
        end
    end

    // Busy next-state: clear on load write first so a same-cycle issue wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant_ld) w_busy_nxt[w_head_rd] = 1'b0;
        if (iss_valid)  w_busy_nxt[iss_rd]    = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Load scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    // Registered write port; x0 requests are consumed without asserting rf_we
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we  <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else if (w_grant_alu) begin
            rf_we  <= (alu_rd != 5'd0);
            rf_a3  <= alu_rd;
            rf_wd3 <= alu_data;
        end else if (w_grant_ld) begin
            rf_we  <= (w_head_rd != 5'd0);
            rf_a3  <= w_head_rd;
            rf_wd3 <= w_head_data;
        end else begin
            rf_we  <= 1'b0;
        end
    end

`ifdef WB_ARB_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
            forced_cnt   <= '0;
        end else begin
            if (w_conflict && (conflict_cnt != 32'hFFFF_FFFF))
                conflict_cnt <= conflict_cnt + 32'd1;
            if (w_enter_load && (forced_cnt != 32'hFFFF_FFFF))
                forced_cnt <= forced_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A second load to a register still awaiting its data is a requester bug,
    // unless the pending one is being written back in this very cycle
    a_single_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(iss_valid && (iss_rd != 5'd0) && r_busy[iss_rd] &&
          !(w_grant_ld && (w_head_rd == iss_rd))));
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed stimulus with a write-port scoreboard for
//            regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd3;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_stall;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt;
    logic [31:0] forced_cnt;
`endif

    int  checks   = 0;
    int  failures = 0;
    wr_t sb[$];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .dec_stall (dec_stall),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3)
`ifdef WB_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt),
        .forced_cnt   (forced_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a3  = a;
        e.wd3 = d;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        ld_valid = v; ld_rd = rd; ld_data = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] rd);
        iss_valid = v; iss_rd = rd;
    endtask

    // Monitor: every write presented on the port must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got a3=%0d wd3=%h, expected no write (t=%0t)",
                         rf_a3, rf_wd3, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wb_a3", {27'd0, rf_a3}, {27'd0, e.a3});
                chk("wb_wd3", rf_wd3, e.wd3);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        alu(0, 0, 0); ld(0, 0, 0); iss(0, 0);
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_rf_a3", {27'd0, rf_a3}, 32'd0);
        chk("reset_rf_wd3", rf_wd3, 32'd0);
        chk("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("reset_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("reset_dec_stall", {31'd0, dec_stall}, 32'd0);
        step(); reset = 1'b0;

        // ALU only
        step(); alu(1, 5, 32'hDEADBEEF); #1;
        chk("alu_only_ready", {31'd0, alu_ready}, 32'd1);
        exp_wr(5, 32'hDEADBEEF);
        step(); alu(0, 0, 0);

        // Load path with RAW stall
        step(); iss(1, 7);
        step(); iss(0, 0); dec_rs1 = 7; ld(1, 7, 32'h12); #1;
        chk("load_stall_set", {31'd0, dec_stall}, 32'd1);
        chk("load_ld_ready", {31'd0, ld_ready}, 32'd1);
        exp_wr(7, 32'h12);
        step(); ld(0, 0, 0);
        step(); #1;
        chk("load_stall_clear", {31'd0, dec_stall}, 32'd0);
        dec_rs1 = 0;

        // Starvation guard: load waits behind 4 ALU writes, then gets forced
        step(); alu(1, 10, 32'hA0); ld(1, 20, 32'hB0); #1;
        chk("starve_ready_c0", {31'd0, alu_ready}, 32'd1);
        exp_wr(10, 32'hA0);
        for (int i = 1; i <= 4; i++) begin
            step(); ld(0, 0, 0); alu(1, 5'(10 + i), 32'hA0 + 32'(i)); #1;
            chk("starve_ready_alu", {31'd0, alu_ready}, 32'd1);
            exp_wr(5'(10 + i), 32'hA0 + 32'(i));
        end
        step(); alu(1, 15, 32'hA5); #1;
        chk("starve_forced_ready", {31'd0, alu_ready}, 32'd0);
        exp_wr(20, 32'hB0);
        step(); #1;
        chk("starve_resume_ready", {31'd0, alu_ready}, 32'd1);
        exp_wr(15, 32'hA5);
        step(); alu(0, 0, 0);

        // Full FIFO backpressure while ALU is busy
        step(); alu(1, 1, 32'h101); ld(1, 21, 32'h21); #1;
        chk("full_ld_ready_c0", {31'd0, ld_ready}, 32'd1);
        exp_wr(1, 32'h101);
        step(); alu(1, 2, 32'h102); ld(1, 22, 32'h22); #1;
        chk("full_ld_ready_c1", {31'd0, ld_ready}, 32'd1);
        exp_wr(2, 32'h102);
        step(); alu(1, 3, 32'h103); ld(1, 23, 32'h23); #1;
        chk("full_ld_ready_c2", {31'd0, ld_ready}, 32'd0);
        exp_wr(3, 32'h103);
        step(); alu(1, 4, 32'h104); #1;
        chk("full_ld_ready_c3", {31'd0, ld_ready}, 32'd0);
        exp_wr(4, 32'h104);
        step(); alu(1, 5, 32'h105); #1;
        exp_wr(5, 32'h105);
        step(); alu(1, 6, 32'h106); #1;
        chk("full_forced_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_ready_not_pop_aware", {31'd0, ld_ready}, 32'd0);
        exp_wr(21, 32'h21);
        step(); #1;
        chk("full_alu_resume", {31'd0, alu_ready}, 32'd1);
        chk("full_ld_ready_after_pop", {31'd0, ld_ready}, 32'd1);
        exp_wr(6, 32'h106);
        step(); alu(0, 0, 0); ld(0, 0, 0);
        exp_wr(22, 32'h22);
        step();
        exp_wr(23, 32'h23);
        step(); step();

        // x0 write is consumed but never reaches the register file
        step(); alu(1, 0, 32'hFFFF); #1;
        chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step(); alu(0, 0, 0); #1;
        chk("x0_no_write", {31'd0, rf_we}, 32'd0);

        // Same-cycle clear and re-issue of r9: set wins
        step(); iss(1, 9);
        step(); iss(0, 0); ld(1, 9, 32'h99); dec_rs2 = 9; #1;
        chk("r9_stall_set", {31'd0, dec_stall}, 32'd1);
        exp_wr(9, 32'h99);
        step(); ld(0, 0, 0); iss(1, 9);
        step(); iss(0, 0); ld(1, 9, 32'h9A); #1;
        chk("r9_set_wins", {31'd0, dec_stall}, 32'd1);
        exp_wr(9, 32'h9A);
        step(); ld(0, 0, 0);
        step(); #1;
        chk("r9_stall_clear", {31'd0, dec_stall}, 32'd0);
        dec_rs2 = 0;

        // Asynchronous reset with a full FIFO and busy bits set
        step(); iss(1, 3); alu(1, 8, 32'h801);
        exp_wr(8, 32'h801);
        step(); iss(1, 4); alu(1, 8, 32'h802); ld(1, 3, 32'h33);
        exp_wr(8, 32'h802);
        step(); iss(0, 0); alu(1, 8, 32'h803); ld(1, 4, 32'h44);
        exp_wr(8, 32'h803);
        step(); alu(1, 8, 32'h804); ld(0, 0, 0); dec_rs1 = 3; #1;
        chk("prereset_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("prereset_dec_stall", {31'd0, dec_stall}, 32'd1);
        exp_wr(8, 32'h804);
        step(); alu(0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_dec_stall", {31'd0, dec_stall}, 32'd0);
        chk("async_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("async_alu_ready", {31'd0, alu_ready}, 32'd1);
        step(); step(); reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("postreset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("postreset_dec_stall", {31'd0, dec_stall}, 32'd0);
        chk("postreset_ld_ready", {31'd0, ld_ready}, 32'd1);
        dec_rs1 = 0;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
